// File: rtl/puzzle_move_expander.sv
// puzzle_move_expander
//   Takes one 8-puzzle parent state per handshake, works out which blank moves
//   are legal (dropping the move that would undo the parent's own move), drives
//   each surviving move through the external combinational move ALU and streams
//   the resulting children downstream over valid/ready.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          parent handshake
//   in_board/in_blank          parent board (pos p at [35-4p -: 4]) and blank position
//   in_has_last/in_last_dir    parent was produced by a move / which move (0 U,1 D,2 L,3 R)
//   in_depth                   parent depth
//   mv_op/mv_blank/mv_board    request to the move ALU
//   mv_board_res/mv_blank_res  combinational ALU result
//   out_valid/out_ready        child handshake
//   out_board/out_blank        child board / blank position
//   out_dir/out_depth          producing move / saturating depth
//   out_goal/out_last          child equals GOAL / final child of this parent
//   err                        one-cycle pulse when a parent with blank > 8 is rejected
//
// state   | meaning
// S_IDLE  | ready for a parent; in_ready = 1
// S_EXPAND| issuing one child per free output slot from the latched move mask
module puzzle_move_expander #(
   parameter logic [35:0] GOAL     = 36'h123456780,
   parameter logic [3:0]  OP_UP    = 4'h8,
   parameter logic [3:0]  OP_DOWN  = 4'h9,
   parameter logic [3:0]  OP_LEFT  = 4'hA,
   parameter logic [3:0]  OP_RIGHT = 4'hB
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [35:0] in_board,
   input  logic [3:0]  in_blank,
   input  logic        in_has_last,
   input  logic [1:0]  in_last_dir,
   input  logic [7:0]  in_depth,
   output logic [3:0]  mv_op,
   output logic [3:0]  mv_blank,
   output logic [35:0] mv_board,
   input  logic [35:0] mv_board_res,
   input  logic [3:0]  mv_blank_res,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [35:0] out_board,
   output logic [3:0]  out_blank,
   output logic [1:0]  out_dir,
   output logic [7:0]  out_depth,
   output logic        out_goal,
   output logic        out_last,
   output logic        err
);

   typedef enum logic {S_IDLE, S_EXPAND} state_t;

   state_t      state_q, state_d;
   logic [3:0]  mask_q;
   logic [35:0] p_board_q;
   logic [3:0]  p_blank_q;
   logic [7:0]  p_depth_q;

   logic [1:0]  col;
   logic [3:0]  new_mask;
   logic        accept, accept_ok, issue;
   logic [1:0]  sel_dir;
   logic [3:0]  sel_onehot, rest;

   // mask bit order: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT (also the issue priority)
   always_comb begin
      col = 2'd2;
      case (in_blank)
         4'd0, 4'd3, 4'd6: col = 2'd0;
         4'd1, 4'd4, 4'd7: col = 2'd1;
         default:          col = 2'd2;
      endcase
      new_mask[0] = (in_blank >= 4'd3);
      new_mask[1] = (in_blank <= 4'd5);
      new_mask[2] = (col != 2'd0);
      new_mask[3] = (col != 2'd2);
      // reverse move differs only in bit 0 of the direction code
      if (in_has_last) new_mask[in_last_dir ^ 2'b01] = 1'b0;
   end

   always_comb begin
      sel_dir    = 2'd0;
      sel_onehot = 4'b0000;
      casez (mask_q)
         4'b???1: begin sel_dir = 2'd0; sel_onehot = 4'b0001; end
         4'b??10: begin sel_dir = 2'd1; sel_onehot = 4'b0010; end
         4'b?100: begin sel_dir = 2'd2; sel_onehot = 4'b0100; end
         4'b1000: begin sel_dir = 2'd3; sel_onehot = 4'b1000; end
         default: begin sel_dir = 2'd0; sel_onehot = 4'b0000; end
      endcase
      rest = mask_q & ~sel_onehot;
   end

   assign accept    = (state_q == S_IDLE) && in_valid;
   assign accept_ok = accept && (in_blank <= 4'd8);
   assign issue     = (state_q == S_EXPAND) && (mask_q != 4'b0000) &&
                      (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      mv_op    = 4'h0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (accept_ok) state_d = S_EXPAND;
         end
         S_EXPAND: begin
            if (mask_q != 4'b0000) begin
               case (sel_dir)
                  2'd0:    mv_op = OP_UP;
                  2'd1:    mv_op = OP_DOWN;
                  2'd2:    mv_op = OP_LEFT;
                  default: mv_op = OP_RIGHT;
               endcase
            end
            if (mask_q == 4'b0000)        state_d = S_IDLE;
            else if (issue && rest == 4'b0000) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mv_blank = p_blank_q;
   assign mv_board = p_board_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q    <= 4'b0000;
         p_board_q <= 36'h0;
         p_blank_q <= 4'h0;
         p_depth_q <= 8'h0;
         out_valid <= 1'b0;
         out_board <= 36'h0;
         out_blank <= 4'h0;
         out_dir   <= 2'd0;
         out_depth <= 8'h0;
         out_goal  <= 1'b0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= accept && !accept_ok;
         if (accept_ok) begin
            mask_q    <= new_mask;
            p_board_q <= in_board;
            p_blank_q <= in_blank;
            p_depth_q <= in_depth;
         end
         if (issue) begin
            out_valid <= 1'b1;
            out_board <= mv_board_res;
            out_blank <= mv_blank_res;
            out_dir   <= sel_dir;
            out_depth <= (p_depth_q == 8'hFF) ? 8'hFF : p_depth_q + 8'd1;
            out_goal  <= (mv_board_res == GOAL);
            out_last  <= (rest == 4'b0000);
            mask_q    <= rest;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_puzzle_move_expander.sv
// Bench for puzzle_move_expander: models the move ALU, keeps a queue of
// expected children and compares each accepted child against it.
module tb_puzzle_move_expander;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [35:0] in_board;
   logic [3:0]  in_blank;
   logic        in_has_last;
   logic [1:0]  in_last_dir;
   logic [7:0]  in_depth;
   logic [3:0]  mv_op, mv_blank;
   logic [35:0] mv_board, mv_board_res;
   logic [3:0]  mv_blank_res;
   logic        out_valid, out_ready;
   logic [35:0] out_board;
   logic [3:0]  out_blank;
   logic [1:0]  out_dir;
   logic [7:0]  out_depth;
   logic        out_goal, out_last, err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [35:0] board;
      logic [3:0]  blank;
      logic [1:0]  dir;
      logic [7:0]  depth;
      logic        goal;
      logic        last;
   } child_t;
   child_t exp_q[$];

   puzzle_move_expander #(
      .GOAL(36'h123456780), .OP_UP(4'h8), .OP_DOWN(4'h9),
      .OP_LEFT(4'hA), .OP_RIGHT(4'hB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_board(in_board), .in_blank(in_blank),
      .in_has_last(in_has_last), .in_last_dir(in_last_dir), .in_depth(in_depth),
      .mv_op(mv_op), .mv_blank(mv_blank), .mv_board(mv_board),
      .mv_board_res(mv_board_res), .mv_blank_res(mv_blank_res),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_board(out_board), .out_blank(out_blank), .out_dir(out_dir),
      .out_depth(out_depth), .out_goal(out_goal), .out_last(out_last),
      .err(err)
   );

   // Move ALU model: swap the blank with the tile at the target position.
   function automatic logic [39:0] alu(input logic [3:0] op, input logic [3:0] b,
                                       input logic [35:0] brd);
      int t, bi;
      logic [35:0] r;
      bi = int'(b);
      case (op)
         4'h8:    t = bi - 3;
         4'h9:    t = bi + 3;
         4'hA:    t = bi - 1;
         4'hB:    t = bi + 1;
         default: t = -1;
      endcase
      if (t < 0 || t > 8 || bi > 8) return {brd, b};
      r = brd;
      r[35-4*bi -: 4] = brd[35-4*t -: 4];
      r[35-4*t -: 4]  = brd[35-4*bi -: 4];
      return {r, 4'(t)};
   endfunction

   assign {mv_board_res, mv_blank_res} = alu(mv_op, mv_blank, mv_board);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [35:0] board, input logic [3:0] blank, input logic [1:0] dir,
                       input logic [7:0] depth, input logic goal, input logic last);
      child_t c;
      c.board = board; c.blank = blank; c.dir = dir;
      c.depth = depth; c.goal = goal; c.last = last;
      exp_q.push_back(c);
   endtask

   // called at a negedge; holds in_valid for one cycle
   task automatic send(input logic [35:0] board, input logic [3:0] blank, input logic hl,
                       input logic [1:0] ld, input logic [7:0] depth);
      check("send_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_board = board; in_blank = blank;
      in_has_last = hl; in_last_dir = ld; in_depth = depth;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // consume n children, comparing each one with the queue head
   task automatic drain(input string tag, input int n);
      int got = 0;
      int budget = 40;
      child_t c;
      while (got < n && budget > 0) begin
         if (out_valid && out_ready) begin
            check({tag, "_q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               c = exp_q.pop_front();
               check({tag, "_board"}, 64'(out_board), 64'(c.board));
               check({tag, "_blank"}, 64'(out_blank), 64'(c.blank));
               check({tag, "_dir"},   64'(out_dir),   64'(c.dir));
               check({tag, "_depth"}, 64'(out_depth), 64'(c.depth));
               check({tag, "_goal"},  64'(out_goal),  64'(c.goal));
               check({tag, "_last"},  64'(out_last),  64'(c.last));
            end
            got++;
         end
         @(negedge clk);
         budget--;
      end
      check({tag, "_child_count"}, 64'(got), 64'(n));
   endtask

   task automatic post_idle(input string tag);
      check({tag, "_q_empty"},   64'(exp_q.size()), 64'd0);
      check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_no_extra"}, 64'(out_valid), 64'd0);
   endtask

   task automatic push_root();
      push(36'h123406758, 4'd4, 2'd0, 8'd1, 1'b0, 1'b0);
      push(36'h123456078, 4'd6, 2'd2, 8'd1, 1'b0, 1'b0);
      push(36'h123456780, 4'd8, 2'd3, 8'd1, 1'b1, 1'b1);
   endtask

   initial begin
      int budget;
      rst_n = 1'b0; in_valid = 1'b0; in_board = 36'h0; in_blank = 4'h0;
      in_has_last = 1'b0; in_last_dir = 2'd0; in_depth = 8'h0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_err",       64'(err),       64'd0);
      check("rst_mv_op",     64'(mv_op),     64'd0);
      check("rst_mv_board",  64'(mv_board),  64'd0);
      check("rst_out_board", 64'(out_board), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // root parent, free-running output
      out_ready = 1'b1;
      push_root();
      send(36'h123456708, 4'd7, 1'b0, 2'd0, 8'd0);
      drain("root", 3);
      post_idle("root");

      // parent produced by LEFT: RIGHT pruned
      push(36'h123406758, 4'd4, 2'd0, 8'd1, 1'b0, 1'b0);
      push(36'h123456078, 4'd6, 2'd2, 8'd1, 1'b0, 1'b1);
      send(36'h123456708, 4'd7, 1'b1, 2'd2, 8'd0);
      drain("prune", 2);
      post_idle("prune");

      // backpressure after the first child
      out_ready = 1'b0;
      push_root();
      send(36'h123456708, 4'd7, 1'b0, 2'd0, 8'd0);
      budget = 20;
      while (!out_valid && budget > 0) begin @(negedge clk); budget--; end
      check("stall_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         check("stall_out_board", 64'(out_board), 64'h123406758);
         check("stall_mv_board",  64'(mv_board),  64'h123456708);
         check("stall_mv_blank",  64'(mv_blank),  64'd7);
         check("stall_mv_op",     64'(mv_op),     64'hA);
         check("stall_in_ready",  64'(in_ready),  64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      drain("stall", 3);
      post_idle("stall");

      // rejected parent
      in_valid = 1'b1; in_board = 36'h123456708; in_blank = 4'd9;
      in_has_last = 1'b0; in_depth = 8'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check("err_pulse",     64'(err),       64'd1);
      check("err_out_valid", 64'(out_valid), 64'd0);
      check("err_in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      check("err_clear",      64'(err),       64'd0);
      check("err_in_ready2",  64'(in_ready),  64'd1);
      check("err_out_valid2", 64'(out_valid), 64'd0);

      // centre blank, saturating depth
      push(36'h103425678, 4'd1, 2'd0, 8'd255, 1'b0, 1'b0);
      push(36'h123475608, 4'd7, 2'd1, 8'd255, 1'b0, 1'b0);
      push(36'h123045678, 4'd3, 2'd2, 8'd255, 1'b0, 1'b0);
      push(36'h123450678, 4'd5, 2'd3, 8'd255, 1'b0, 1'b1);
      send(36'h123405678, 4'd4, 1'b0, 2'd0, 8'd255);
      drain("sat", 4);
      post_idle("sat");

      // reset while the second child is pending
      push_root();
      send(36'h123456708, 4'd7, 1'b0, 2'd0, 8'd0);
      drain("rst_first", 1);
      check("rst_pending_valid", 64'(out_valid), 64'd1);
      check("rst_pending_board", 64'(out_board), 64'h123456078);
      out_ready = 1'b0;
      exp_q.delete();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 64'(out_valid), 64'd0);
      check("rst_async_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("rst_no_child", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      push(36'h123406758, 4'd4, 2'd0, 8'd1, 1'b0, 1'b0);
      push(36'h123456078, 4'd6, 2'd2, 8'd1, 1'b0, 1'b1);
      send(36'h123456708, 4'd7, 1'b1, 2'd2, 8'd0);
      drain("after_rst", 2);
      post_idle("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
